// File: rtl/multiplier_adapter_if.sv
// Operand/result bundle for the modular multiplier.
// The master drives operands; the slave returns product and Done.
interface multiplier_adapter_if #(
  parameter int P_WIDTH = 16
);
  logic [P_WIDTH-1:0] a;
  logic [P_WIDTH-1:0] b;
  logic [P_WIDTH-1:0] product;
  logic               Done;

  modport master (
    output a,
    output b,
    input  product,
    input  Done
  );

  modport slave (
    input  a,
    input  b,
    output product,
    output Done
  );
endinterface

// File: rtl/multiplier_adapter.sv
// Sequential (a*b) mod P_MOD: reduce a, reduce b, then MSB-first
// double-and-add. Launched by reset release; Done is sticky.
module multiplier_adapter #(
  parameter int P_WIDTH = 16,
  parameter int P_MOD   = 101
) (
  input  logic                clk,
  input  logic                Reset,
  multiplier_adapter_if.slave bus
);
  localparam int W  = P_WIDTH;
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W:0]    PM   = (W+1)'(P_MOD);
  localparam logic [IW-1:0] IMAX = IW'(W - 1);

  typedef enum logic [2:0] {
    IDLE, RED_A, RED_B, MUL, DONE
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] i;
  logic [W-1:0]  a_q, b_q, ar, br;
  logic [W:0]    r, acc;
  logic [W:0]    rn, m1, m2;
  logic          last;
  logic          rbit;
  logic          ld_out;

  assign last = (i == '0);

  // State register; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!Reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state: each arithmetic phase lasts W cycles.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = RED_A;
      RED_A: if (last) state_n = RED_B;
      RED_B: if (last) state_n = MUL;
      MUL:   if (last) state_n = DONE;
      DONE:  state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode: results are latched only once in DONE.
  always_comb begin
    ld_out = (state == DONE);
  end

  // One restoring-reduction step and one double-and-add step.
  always_comb begin
    rbit = (state == RED_B) ? b_q[i] : a_q[i];
    rn   = {r[W-1:0], rbit};
    if (rn >= PM) rn = rn - PM;
    m1 = {acc[W-1:0], 1'b0};
    if (m1 >= PM) m1 = m1 - PM;
    m2 = m1 + (ar[i] ? {1'b0, br} : '0);
    if (m2 >= PM) m2 = m2 - PM;
  end

  // Datapath registers and the registered outputs.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      i           <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ar          <= '0;
      br          <= '0;
      r           <= '0;
      acc         <= '0;
      bus.product <= '0;
      bus.Done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          a_q <= bus.a;
          b_q <= bus.b;
          i   <= IMAX;
          r   <= '0;
          acc <= '0;
        end
        RED_A, RED_B: begin
          i <= last ? IMAX : i - 1'b1;
          r <= last ? '0 : rn;
          if (last && state == RED_A) ar <= rn[W-1:0];
          if (last && state == RED_B) br <= rn[W-1:0];
        end
        MUL: begin
          i   <= last ? IMAX : i - 1'b1;
          acc <= m2;
        end
        default: ;
      endcase
      if (ld_out) begin
        bus.product <= acc[W-1:0];
        bus.Done    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_multiplier_adapter.sv
// Directed bench for multiplier_adapter (P_WIDTH=16, P_MOD=101).
// Done must appear at the 50th edge after reset release.
module tb_multiplier_adapter;
  logic clk = 1'b0;
  logic Reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  multiplier_adapter_if #(.P_WIDTH(16)) bus ();

  multiplier_adapter #(
    .P_WIDTH(16),
    .P_MOD  (101)
  ) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hold reset for one edge with the given operands, then release.
  task automatic start(input logic [15:0] va,
                       input logic [15:0] vb);
    Reset = 1'b0;
    bus.a = va;
    bus.b = vb;
    @(posedge clk);
    @(negedge clk);
    chk("rst_done", 32'(bus.Done), 0);
    chk("rst_prod", 32'(bus.product), 0);
    Reset = 1'b1;
  endtask

  // Walk 50 edges; outputs must stay zero until the last one.
  // chg >= 0 swaps operands to 7/8 after that edge.
  task automatic run(input string tag,
                     input logic [15:0] exp,
                     input int chg);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == chg) begin
        bus.a = 16'd7;
        bus.b = 16'd8;
      end
      if (k < 49) begin
        chk({tag, "_busy_done"}, 32'(bus.Done), 0);
        chk({tag, "_busy_prod"}, 32'(bus.product), 0);
      end else begin
        chk({tag, "_done"}, 32'(bus.Done), 1);
        chk({tag, "_prod"}, 32'(bus.product), 32'(exp));
      end
    end
  endtask

  initial begin
    bus.a = '0;
    bus.b = '0;
    @(negedge clk);

    start(16'd123, 16'd456);
    run("basic", 16'd33, -1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("hold_done", 32'(bus.Done), 1);
      chk("hold_prod", 32'(bus.product), 33);
    end

    start(16'd0, 16'd456);
    run("a_zero", 16'd0, -1);
    start(16'd101, 16'd5);
    run("a_mod", 16'd0, -1);
    start(16'd5, 16'd101);
    run("b_mod", 16'd0, -1);
    start(16'hFFFF, 16'hFFFF);
    run("max", 16'd95, -1);
    start(16'd100, 16'd100);
    run("pm1", 16'd1, -1);
    start(16'd123, 16'd456);
    run("ign_in", 16'd33, 4);

    // Abort at edge 20, then restart with 7*8.
    start(16'd123, 16'd456);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy", 32'(bus.Done), 0);
    end
    start(16'd7, 16'd8);
    run("restart", 16'd56, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
